mux4_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one 4:1 multiplexer among four requesters. It arbitrates the request lines, drives the mux select and a one-hot grant, and bounds each owner's tenure under contention. The selected data is registered with a valid flag for the downstream consumer. The block sits directly in front of the team's 4:1 mux datapath and contains its own select/data stage.

---
 rtl/mux4_rr_scheduler.sv | 110 +++++++++++
 tb/tb_mux4_rr_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_scheduler.sv
// Round-robin scheduler for a shared 4:1 mux. Arbitrates four request
// lines, registers a one-hot grant plus mux select, limits each owner's
// tenure to MAX_HOLD cycles while others wait, and registers the selected
// data with a valid flag for the downstream consumer.
module mux4_rr_scheduler #(
  parameter int DW       = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req,
  input  logic [4*DW-1:0] din,
  output logic [3:0]    gnt,
  output logic [1:0]    sel,
  output logic [DW-1:0] dout,
  output logic          dout_valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] MAX_H = 8'(MAX_HOLD);

  state_t       state, state_nxt;
  logic [1:0]   ptr, ptr_nxt;
  logic [7:0]   hold_cnt, hold_nxt;
  logic [3:0]   gnt_nxt;
  logic [1:0]   sel_nxt;
  logic [1:0]   win;
  logic         found;
  logic [DW-1:0] ch [4];

  // Split the flat data bus into per-channel slices for the output mux.
  for (genvar k = 0; k < 4; k++) begin : g_ch
    assign ch[k] = din[k*DW +: DW];
  end

  // Round-robin search: first requesting channel starting at ptr.
  always_comb begin
    // NOTE: every variable written here gets a default first so no latch is inferred.
    found = 1'b0;
    win   = ptr;
    // Scan from the farthest offset down so the nearest requester wins last.
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) begin
        found = 1'b1;
        win   = ptr + 2'(i);
      end
    end
  end

  // Next-state logic: ownership, tenure counter, pointer and grant outputs.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    gnt_nxt   = gnt;
    sel_nxt   = sel;

    if (state == GRANT && req[sel] && hold_cnt < MAX_H) begin
      // Owner keeps the mux until its tenure expires.
      hold_nxt = hold_cnt + 8'd1;
    end else if (state == GRANT && req[sel] && (req & ~(4'b0001 << sel)) == 4'b0000) begin
      // Tenure expired but nobody else waits: restart the owner's tenure.
      hold_nxt = 8'd1;
    end else if (found) begin
      // New grant: from idle, on release, or on tenure expiry. On expiry the
      // owner loses because ptr already points past it.
      state_nxt = GRANT;
      gnt_nxt   = 4'b0001 << win;
      sel_nxt   = win;
      ptr_nxt   = win + 2'd1;
      hold_nxt  = 8'd1;
    end else begin
      // No requester at all: go idle, sel keeps its last value.
      state_nxt = IDLE;
      gnt_nxt   = 4'b0000;
      hold_nxt  = 8'd0;
    end
  end

  // State, pointer, tenure and grant registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      hold_cnt <= 8'd0;
      gnt      <= 4'b0000;
      sel      <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
    end
  end

  // Data stage: register the currently selected channel and its validity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout       <= ch[sel];
      dout_valid <= (state == GRANT) && req[sel];
    end
  end

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// Self-checking bench for mux4_rr_scheduler: reset, a directed vector
// table, hand-written multi-cycle corner cases and a randomized run
// against a behavioural ownership model.
module tb_mux4_rr_scheduler;

  localparam int DW       = 4;
  localparam int MAX_HOLD = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    req;
  logic [4*DW-1:0] din;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic [DW-1:0] dout;
  logic          dout_valid;

  int checks   = 0;
  int failures = 0;

  mux4_rr_scheduler #(.DW(DW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .din(din),
    .gnt(gnt), .sel(sel), .dout(dout), .dout_valid(dout_valid)
  );

  always #5 clk = ~clk;

  // Packed view of all outputs: {gnt, sel, dout, dout_valid}.
  function automatic logic [10:0] pack(input logic [3:0] g, input logic [1:0] s,
                                       input logic [3:0] d, input logic v);
    return {g, s, d, v};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit         m_busy;
  int         m_owner, m_ptr, m_hold;
  logic [3:0] m_dout;
  logic       m_valid;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_dout = '0; m_valid = 0;
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++)
      if (r[(p + i) % 4]) return (p + i) % 4;
    return -1;
  endfunction

  // Advance the model by one clock edge with the given inputs.
  task automatic model_step(input logic [3:0] r, input logic [4*DW-1:0] d);
    int w;
    m_dout  = d[m_owner*DW +: DW];
    m_valid = m_busy && r[m_owner];
    if (m_busy && r[m_owner] && m_hold < MAX_HOLD) begin
      m_hold++;
    end else if (m_busy && r[m_owner] && (r & ~(4'(1) << m_owner)) == 0) begin
      m_hold = 1;
    end else begin
      w = pick(r, m_ptr);
      if (w < 0) begin
        m_busy = 0; m_hold = 0;
      end else begin
        m_busy = 1; m_owner = w; m_ptr = (w + 1) % 4; m_hold = 1;
      end
    end
  endtask

  function automatic logic [10:0] model_out();
    return pack(m_busy ? 4'(4'(1) << m_owner) : 4'b0000, 2'(m_owner), m_dout, m_valid);
  endfunction

  // ---------------- helpers ----------------
  task automatic apply_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Drive inputs at the falling edge, then move to just past the rising edge.
  task automatic cycle(input logic [3:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic [3:0] dout;
    logic       valid;
  } vec_t;

  vec_t tbl [11];
  localparam logic [15:0] DIN_FIX = 16'hDCBA;  // ch0=A ch1=B ch2=C ch3=D

  logic [3:0] ch_val [4];
  logic [3:0] r_req;
  int         own, run_len, prev_own;

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    din   = '0;
    for (int k = 0; k < 4; k++) ch_val[k] = DIN_FIX[k*DW +: DW];

    // ---- Reset / idle ----
    #2;
    check("reset_outputs", 32'(pack(gnt, sel, dout, dout_valid)), 32'(11'd0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      cycle(4'b0000);
      check("idle_after_reset", 32'(pack(gnt, sel, dout, dout_valid)), 32'(11'd0));
    end

    // ---- Directed table: release handover, go idle, pointer order ----
    tbl[0]  = '{4'b0101, 4'b0001, 2'd0, 4'hA, 1'b0};
    tbl[1]  = '{4'b0101, 4'b0001, 2'd0, 4'hA, 1'b1};
    tbl[2]  = '{4'b0101, 4'b0001, 2'd0, 4'hA, 1'b1};
    tbl[3]  = '{4'b0100, 4'b0100, 2'd2, 4'hA, 1'b0};  // drop req[0]: no idle gap
    tbl[4]  = '{4'b0100, 4'b0100, 2'd2, 4'hC, 1'b1};
    tbl[5]  = '{4'b0000, 4'b0000, 2'd2, 4'hC, 1'b0};  // release, nobody waiting
    tbl[6]  = '{4'b0000, 4'b0000, 2'd2, 4'hC, 1'b0};
    tbl[7]  = '{4'b1010, 4'b1000, 2'd3, 4'hC, 1'b0};  // ptr=3 so ch3 beats ch1
    tbl[8]  = '{4'b1010, 4'b1000, 2'd3, 4'hD, 1'b1};
    tbl[9]  = '{4'b0010, 4'b0010, 2'd1, 4'hD, 1'b0};
    tbl[10] = '{4'b0110, 4'b0010, 2'd1, 4'hB, 1'b1};  // ch1 keeps mux (hold 2)
    apply_reset();
    din = DIN_FIX;
    foreach (tbl[i]) begin
      @(negedge clk);
      cycle(tbl[i].req);
      check($sformatf("table[%0d]", i), 32'(pack(gnt, sel, dout, dout_valid)),
            32'(pack(tbl[i].gnt, tbl[i].sel, tbl[i].dout, tbl[i].valid)));
    end
    // Hold restarted at 1 after handover to ch1: it keeps 6 more cycles, then ch2.
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      cycle(4'b0110);
      check("handover_tenure", 32'(gnt), 32'(c < 6 ? 4'b0010 : 4'b0100));
    end

    // ---- Simultaneous requests: 0,1,2,3,0 each for MAX_HOLD cycles ----
    apply_reset();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      cycle(4'b1111);
      own = (c / MAX_HOLD) % 4;
      check("all_request", 32'(pack(gnt, sel, dout, dout_valid)),
            32'(pack(4'(4'(1) << own), 2'(own),
                     c == 0 ? ch_val[0] : ch_val[((c - 1) / MAX_HOLD) % 4], c != 0)));
    end

    // ---- Sole requester: ch3 keeps the mux past MAX_HOLD ----
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      cycle(4'b1000);
      check("sole_requester", 32'(pack(gnt, sel, dout, dout_valid)),
            32'(pack(4'b1000, 2'd3, c == 0 ? ch_val[0] : ch_val[3], c != 0)));
    end

    // ---- Wrap-around: owner ch3 passes to ch0 after MAX_HOLD ----
    apply_reset();
    @(negedge clk);
    cycle(4'b1000);
    check("wrap_first_grant", 32'(gnt), 32'(4'b1000));
    for (int c = 1; c < 10; c++) begin
      @(negedge clk);
      cycle(4'b1001);
      check("wrap_rotate", 32'(gnt), 32'(c < MAX_HOLD ? 4'b1000 : 4'b0001));
    end

    // ---- Mid-tenure asynchronous reset ----
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      cycle(4'b0100);
    end
    check("pre_reset_owner", 32'(gnt), 32'(4'b0100));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_now", 32'({gnt, sel, dout_valid}), 32'(7'd0));
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b0110);
    check("after_reset_winner", 32'({gnt, sel}), 32'({4'b0010, 2'd1}));

    // ---- Randomized run against the reference model ----
    apply_reset();
    r_req    = 4'b0000;
    prev_own = -1;
    run_len  = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 5) == 0) r_req[b] = ~r_req[b];
      din = 16'($urandom);
      model_step(r_req, din);
      cycle(r_req);
      check("random_vs_model", 32'(pack(gnt, sel, dout, dout_valid)), 32'(model_out()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
